// File: rtl/finder_pkg.sv
// Shared types and byte helpers for the dictionary finder and related parser blocks.
package finder_pkg;

   typedef enum logic [2:0] {IDLE, SKP, TOK, LNK, LEN, CMP, NXT, DONE} state_t;

   localparam int         IMM_BIT = 7;
   localparam int         HID_BIT = 6;
   localparam logic [7:0] LEN_MSK = 8'h1F;

   // NUL is the TIB terminator, so it is deliberately not whitespace.
   function automatic logic is_ws(input logic [7:0] b);
      return (b != 8'h00) && (b <= 8'h20);
   endfunction

   function automatic logic [7:0] fold(input logic [7:0] b);
      if ((b >= 8'h61) && (b <= 8'h7A)) return b - 8'h20;
      return b;
   endfunction

endpackage

// File: rtl/char_cmp.sv
// Byte comparator: operand A is captured on i_ld, operand B compared live, optional ASCII case fold.
module char_cmp
   import finder_pkg::*;
#(
   parameter int DSZ = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           i_ld,
   input  logic           i_icase,
   input  logic [DSZ-1:0] i_a,
   input  logic [DSZ-1:0] i_b,
   output logic           o_eq
);

   logic [DSZ-1:0] r_a;
   logic [DSZ-1:0] w_a_f;
   logic [DSZ-1:0] w_b_f;

   always_comb begin
      w_a_f = i_a;
      w_b_f = i_b;
      if (i_icase) begin
         w_a_f[7:0] = fold(i_a[7:0]);
         w_b_f[7:0] = fold(i_b[7:0]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    r_a <= '0;
      else if (i_ld) r_a <= w_a_f;
   end

   assign o_eq = (r_a == w_b_f);

endmodule

// File: rtl/dict_finder.sv
// Tokenises the next TIB word and walks the linked-list dictionary looking for it.
//  state | meaning
//  IDLE  | waiting for start, mb_ai tracks tib
//  SKP   | skipping leading whitespace
//  TOK   | measuring the token up to its delimiter
//  LNK   | reading the little-endian link field of word w
//  LEN   | reading the length byte, length-first reject
//  CMP   | name compare, dict byte then TIB byte per character
//  NXT   | follow link or stop at end of dictionary
//  DONE  | one-cycle result pulse
module dict_finder
   import finder_pkg::*;
#(
   parameter int                 DSZ     = 8,
   parameter int                 ASZ     = 17,
   parameter int                 LSZ     = 2,
   parameter int                 WMAX    = 31,
   parameter logic [LSZ*8-1:0]   END_LNK = 'hFFFF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [ASZ-1:0] ctx,
   input  logic [ASZ-1:0] tib,
   input  logic           icase,
   output logic [ASZ-1:0] mb_ai,
   output logic           mb_we,
   input  logic [DSZ-1:0] mb_vo,
   output logic           bsy,
   output logic           done,
   output logic           hit,
   output logic           eot,
   output logic           imm,
   output logic [ASZ-1:0] wa,
   output logic [ASZ-1:0] pfa,
   output logic [ASZ-1:0] tib_nxt
);

   localparam int             LW     = LSZ * 8;
   localparam logic [ASZ-1:0] A_ONE  = ASZ'(1);
   localparam logic [ASZ-1:0] A_LSZ  = ASZ'(LSZ);
   localparam logic [ASZ-1:0] A_HDR  = ASZ'(LSZ + 1);
   localparam logic [1:0]     L_LAST = 2'(LSZ - 1);
   localparam logic [5:0]     T_MAX  = 6'(WMAX);
   localparam logic [5:0]     T_SAT  = 6'h3F;
   localparam logic [7:0]     W_MSK  = LEN_MSK & 8'(WMAX);

   state_t         r_state,   w_state_nxt;
   logic [ASZ-1:0] r_ai,      w_ai_nxt;
   logic [ASZ-1:0] r_w,       w_w_nxt;
   logic [ASZ-1:0] r_tok,     w_tok_nxt;
   logic           r_icase,   w_icase_nxt;
   logic [5:0]     r_tcnt,    w_tcnt_nxt;
   logic [5:0]     r_cidx,    w_cidx_nxt;
   logic [LW-1:0]  r_link,    w_link_nxt;
   logic [1:0]     r_lcnt,    w_lcnt_nxt;
   logic [7:0]     r_lenb,    w_lenb_nxt;
   logic           r_ph,      w_ph_nxt;
   logic           r_hit,     w_hit_nxt;
   logic           r_eot,     w_eot_nxt;
   logic           r_imm,     w_imm_nxt;
   logic [ASZ-1:0] r_wa,      w_wa_nxt;
   logic [ASZ-1:0] r_pfa,     w_pfa_nxt;
   logic [ASZ-1:0] r_tn,      w_tn_nxt;

   logic [7:0]        w_byte;
   logic              w_ld;
   logic              w_eq;
   logic [ASZ+LW-1:0] w_link_ext;
   logic [ASZ-1:0]    w_link_a;

   assign w_byte     = mb_vo[7:0];
   assign w_link_ext = {{ASZ{1'b0}}, r_link};
   assign w_link_a   = w_link_ext[ASZ-1:0];

   char_cmp #(.DSZ(DSZ)) u_cmp (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_ld    (w_ld),
      .i_icase (r_icase),
      .i_a     (mb_vo),
      .i_b     (mb_vo),
      .o_eq    (w_eq)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_ai    <= '0;
         r_w     <= '0;
         r_tok   <= '0;
         r_icase <= 1'b0;
         r_tcnt  <= '0;
         r_cidx  <= '0;
         r_link  <= '0;
         r_lcnt  <= '0;
         r_lenb  <= '0;
         r_ph    <= 1'b0;
         r_hit   <= 1'b0;
         r_eot   <= 1'b0;
         r_imm   <= 1'b0;
         r_wa    <= '0;
         r_pfa   <= '0;
         r_tn    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ai    <= w_ai_nxt;
         r_w     <= w_w_nxt;
         r_tok   <= w_tok_nxt;
         r_icase <= w_icase_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_cidx  <= w_cidx_nxt;
         r_link  <= w_link_nxt;
         r_lcnt  <= w_lcnt_nxt;
         r_lenb  <= w_lenb_nxt;
         r_ph    <= w_ph_nxt;
         r_hit   <= w_hit_nxt;
         r_eot   <= w_eot_nxt;
         r_imm   <= w_imm_nxt;
         r_wa    <= w_wa_nxt;
         r_pfa   <= w_pfa_nxt;
         r_tn    <= w_tn_nxt;
      end
   end

   // Byte states take two cycles: r_ph=0 waits on the read, r_ph=1 consumes mb_vo.
   always_comb begin
      w_state_nxt = r_state;
      w_ai_nxt    = r_ai;
      w_w_nxt     = r_w;
      w_tok_nxt   = r_tok;
      w_icase_nxt = r_icase;
      w_tcnt_nxt  = r_tcnt;
      w_cidx_nxt  = r_cidx;
      w_link_nxt  = r_link;
      w_lcnt_nxt  = r_lcnt;
      w_lenb_nxt  = r_lenb;
      w_ph_nxt    = r_ph;
      w_hit_nxt   = r_hit;
      w_eot_nxt   = r_eot;
      w_imm_nxt   = r_imm;
      w_wa_nxt    = r_wa;
      w_pfa_nxt   = r_pfa;
      w_tn_nxt    = r_tn;
      w_ld        = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_ai_nxt = tib;
            if (start) begin
               w_state_nxt = SKP;
               w_w_nxt     = ctx;
               w_icase_nxt = icase;
               w_ph_nxt    = 1'b0;
            end
         end
         SKP: begin
            w_ph_nxt = ~r_ph;
            if (r_ph) begin
               if (w_byte == 8'h00) begin
                  w_state_nxt = DONE;
                  w_hit_nxt   = 1'b0;
                  w_eot_nxt   = 1'b1;
                  w_imm_nxt   = 1'b0;
                  w_tn_nxt    = r_ai;
               end else if (is_ws(w_byte)) begin
                  w_ai_nxt = r_ai + A_ONE;
               end else begin
                  w_state_nxt = TOK;
                  w_tok_nxt   = r_ai;
                  w_tcnt_nxt  = 6'd1;
                  w_ai_nxt    = r_ai + A_ONE;
               end
            end
         end
         TOK: begin
            w_ph_nxt = ~r_ph;
            if (r_ph) begin
               if ((w_byte == 8'h00) || is_ws(w_byte)) begin
                  w_tn_nxt  = (w_byte == 8'h00) ? r_ai : r_ai + A_ONE;
                  w_eot_nxt = 1'b0;
                  if (r_tcnt > T_MAX) begin
                     w_state_nxt = DONE;
                     w_hit_nxt   = 1'b0;
                     w_imm_nxt   = 1'b0;
                  end else begin
                     w_state_nxt = LNK;
                     w_ai_nxt    = r_w;
                     w_lcnt_nxt  = '0;
                  end
               end else begin
                  if (r_tcnt != T_SAT) w_tcnt_nxt = r_tcnt + 6'd1;
                  w_ai_nxt = r_ai + A_ONE;
               end
            end
         end
         LNK: begin
            w_ph_nxt = ~r_ph;
            if (r_ph) begin
               w_link_nxt[int'(r_lcnt)*8 +: 8] = w_byte;
               if (r_lcnt == L_LAST) begin
                  w_state_nxt = LEN;
                  w_ai_nxt    = r_w + A_LSZ;
               end else begin
                  w_lcnt_nxt = r_lcnt + 2'd1;
                  w_ai_nxt   = r_ai + A_ONE;
               end
            end
         end
         LEN: begin
            w_ph_nxt = ~r_ph;
            if (r_ph) begin
               w_lenb_nxt = w_byte;
               if (w_byte[HID_BIT] || ((w_byte & W_MSK) != {2'b00, r_tcnt})) begin
                  w_state_nxt = NXT;
               end else begin
                  w_state_nxt = CMP;
                  w_ai_nxt    = r_w + A_HDR;
                  w_cidx_nxt  = '0;
               end
            end
         end
         CMP: begin
            // r_ph=0: mb_vo holds TIB byte of char r_cidx-1; r_ph=1: dict byte of char r_cidx.
            if (!r_ph) begin
               if ((r_cidx != 6'd0) && !w_eq) begin
                  w_state_nxt = NXT;
               end else if (r_cidx == r_tcnt) begin
                  w_state_nxt = DONE;
                  w_hit_nxt   = 1'b1;
                  w_eot_nxt   = 1'b0;
                  w_imm_nxt   = r_lenb[IMM_BIT];
                  w_wa_nxt    = r_w;
                  w_pfa_nxt   = r_w + A_HDR + ASZ'(r_tcnt);
               end else begin
                  w_ai_nxt = r_tok + ASZ'(r_cidx);
                  w_ph_nxt = 1'b1;
               end
            end else begin
               w_ld       = 1'b1;
               w_ai_nxt   = r_w + A_HDR + ASZ'(r_cidx) + A_ONE;
               w_cidx_nxt = r_cidx + 6'd1;
               w_ph_nxt   = 1'b0;
            end
         end
         NXT: begin
            w_ph_nxt = 1'b0;
            if (r_link == END_LNK) begin
               w_state_nxt = DONE;
               w_hit_nxt   = 1'b0;
               w_eot_nxt   = 1'b0;
               w_imm_nxt   = 1'b0;
            end else begin
               w_state_nxt = LNK;
               w_w_nxt     = w_link_a;
               w_ai_nxt    = w_link_a;
               w_lcnt_nxt  = '0;
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign mb_ai   = r_ai;
   assign mb_we   = 1'b0;
   assign bsy     = (r_state != IDLE) && (r_state != DONE);
   assign done    = (r_state == DONE);
   assign hit     = r_hit;
   assign eot     = r_eot;
   assign imm     = r_imm;
   assign wa      = r_wa;
   assign pfa     = r_pfa;
   assign tib_nxt = r_tn;

endmodule

// File: tb/tb_dict_finder.sv
// Directed bench for dict_finder with a behavioural dictionary-search model and a done-pulse checker.
module tb_dict_finder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        icase = 1'b0;
   logic [16:0] ctx = '0;
   logic [16:0] tib = '0;
   logic [16:0] mb_ai;
   logic        mb_we;
   logic [7:0]  mb_vo = 8'h00;
   logic        bsy, done, hit, eot, imm;
   logic [16:0] wa, pfa, tib_nxt;

   bit [7:0] mem [0:131071];

   int tests = 0;
   int fails = 0;
   int done_cnt = 0;
   bit exp_valid = 1'b0;
   bit e_hit, e_eot, e_imm;
   logic [16:0] e_wa, e_pfa, e_tn;
   bit track = 1'b0;
   logic [16:0] max_ai = '0;

   dict_finder dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .ctx     (ctx),
      .tib     (tib),
      .icase   (icase),
      .mb_ai   (mb_ai),
      .mb_we   (mb_we),
      .mb_vo   (mb_vo),
      .bsy     (bsy),
      .done    (done),
      .hit     (hit),
      .eot     (eot),
      .imm     (imm),
      .wa      (wa),
      .pfa     (pfa),
      .tib_nxt (tib_nxt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) mb_vo <= mem[mb_ai];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic bit ws_m(input bit [7:0] b);
      return (b >= 8'd1) && (b <= 8'd32);
   endfunction

   function automatic bit [7:0] up_m(input bit [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) ? b - 8'd32 : b;
   endfunction

   task automatic model(input logic [16:0] c, input logic [16:0] t, input bit ic);
      logic [16:0] p, s, w, lnk;
      bit [7:0]    lb, a, b;
      int          n;
      bit          same;
      e_hit = 0; e_eot = 0; e_imm = 0; e_wa = '0; e_pfa = '0;
      p = t;
      while (ws_m(mem[p])) p = 17'(p + 1);
      if (mem[p] == 8'h00) begin
         e_eot = 1;
         e_tn  = p;
         return;
      end
      s = p;
      while ((mem[p] != 8'h00) && !ws_m(mem[p])) p = 17'(p + 1);
      n = int'(p - s);
      e_tn = (mem[p] == 8'h00) ? p : 17'(p + 1);
      if (n > 31) return;
      w = c;
      for (int g = 0; g < 64; g++) begin
         lnk = {1'b0, mem[17'(w + 1)], mem[w]};
         lb  = mem[17'(w + 2)];
         if (!lb[6] && (int'(lb[4:0]) == n)) begin
            same = 1;
            for (int k = 0; k < n; k++) begin
               a = mem[17'(w + 3 + k)];
               b = mem[17'(s + k)];
               if (ic) begin a = up_m(a); b = up_m(b); end
               if (a != b) same = 0;
            end
            if (same) begin
               e_hit = 1;
               e_imm = lb[7];
               e_wa  = w;
               e_pfa = 17'(w + 3 + n);
               return;
            end
         end
         if (lnk == 17'h0FFFF) return;
         w = lnk;
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (track && bsy && (mb_ai > max_ai)) max_ai = mb_ai;
         if (done) begin
            done_cnt++;
            if (!exp_valid) begin
               tests++;
               fails++;
               $display("FAIL unexpected_done: got done=1 required done=0");
            end else begin
               chk("m_hit", hit, e_hit);
               chk("m_eot", eot, e_eot);
               chk("m_tib_nxt", tib_nxt, e_tn);
               chk("m_bsy_at_done", bsy, 0);
               chk("m_mb_we", mb_we, 0);
               if (e_hit) begin
                  chk("m_wa", wa, e_wa);
                  chk("m_pfa", pfa, e_pfa);
                  chk("m_imm", imm, e_imm);
               end
            end
         end
      end
   end

   task automatic put_str(input logic [16:0] a, input string s);
      for (int i = 0; i < s.len(); i++) mem[17'(a + i)] = s[i];
      mem[17'(a + s.len())] = 8'h00;
   endtask

   task automatic put_word(input logic [16:0] a, input logic [15:0] lnk, input bit [7:0] lb, input string nm);
      mem[a] = lnk[7:0];
      mem[17'(a + 1)] = lnk[15:8];
      mem[17'(a + 2)] = lb;
      for (int i = 0; i < nm.len(); i++) mem[17'(a + 3 + i)] = nm[i];
   endtask

   task automatic launch(input logic [16:0] c, input logic [16:0] t, input bit ic);
      @(posedge clk); #1;
      ctx = c; tib = t; icase = ic;
      model(c, t, ic);
      exp_valid = 1; done_cnt = 0; max_ai = '0; track = 1;
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic finish_search();
      int i;
      for (i = 0; i < 3000; i++) begin
         if (done) break;
         @(posedge clk); #1;
      end
      if (!done) chk("timeout_done", 0, 1);
      @(negedge clk); #1;
      exp_valid = 0;
      track = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("single_done", done_cnt, 1);
   endtask

   task automatic search(input logic [16:0] c, input logic [16:0] t, input bit ic);
      launch(c, t, ic);
      finish_search();
   endtask

   initial begin
      put_word(17'h0100, 16'hFFFF, 8'h03, "DUP");
      put_word(17'h0110, 16'h0100, 8'h04, "SWAP");
      put_str(17'h0200, "  DUP ");
      put_str(17'h0300, "dup");
      put_str(17'h0400, "SWAP");
      for (int i = 0; i < 40; i++) mem[17'(16 + i)] = 8'h58;
      mem[17'h0038] = 8'h00;
      for (int i = 0; i < 32; i++) mem[17'(64 + i)] = 8'h59;
      mem[17'h0060] = 8'h00;
      for (int i = 0; i < 31; i++) mem[17'(128 + i)] = 8'h5A;
      mem[17'h009F] = 8'h00;

      #12;
      chk("rst_bsy", bsy, 0);
      chk("rst_done", done, 0);
      chk("rst_hit", hit, 0);
      chk("rst_eot", eot, 0);
      chk("rst_imm", imm, 0);
      chk("rst_wa", wa, 0);
      chk("rst_pfa", pfa, 0);
      chk("rst_tib_nxt", tib_nxt, 0);
      chk("rst_mb_ai", mb_ai, 0);
      chk("rst_mb_we", mb_we, 0);
      @(negedge clk); rst_n = 1;

      search(17'h0110, 17'h0200, 0);
      chk("dup_hit", hit, 1);
      chk("dup_wa", wa, 17'h0100);
      chk("dup_pfa", pfa, 17'h0106);
      chk("dup_tib_nxt", tib_nxt, 17'h0206);
      chk("dup_imm", imm, 0);

      search(17'h0110, 17'h0300, 0);
      chk("lc_nocase_hit", hit, 0);
      chk("lc_nocase_tn", tib_nxt, 17'h0303);

      search(17'h0110, 17'h0300, 1);
      chk("lc_icase_hit", hit, 1);
      chk("lc_icase_wa", wa, 17'h0100);

      mem[17'h0112] = 8'h44;
      search(17'h0110, 17'h0400, 0);
      chk("hidden_hit", hit, 0);

      mem[17'h0112] = 8'h84;
      search(17'h0110, 17'h0400, 0);
      chk("imm_hit", hit, 1);
      chk("imm_imm", imm, 1);
      chk("imm_wa", wa, 17'h0110);
      chk("imm_pfa", pfa, 17'h0117);

      put_str(17'h0200, "   ");
      search(17'h0110, 17'h0200, 0);
      chk("eot_eot", eot, 1);
      chk("eot_hit", hit, 0);
      chk("eot_tn", tib_nxt, 17'h0203);
      put_str(17'h0200, "  DUP ");

      search(17'h0110, 17'h0010, 0);
      chk("long40_hit", hit, 0);
      chk("long40_tn", tib_nxt, 17'h0038);
      chk("long40_no_dict", max_ai < 17'h0100, 1);

      search(17'h0110, 17'h0040, 0);
      chk("long32_hit", hit, 0);
      chk("long32_no_dict", max_ai < 17'h0100, 1);

      search(17'h0110, 17'h0080, 0);
      chk("len31_hit", hit, 0);
      chk("len31_dict_read", max_ai >= 17'h0100, 1);

      // reset while the DUP name compare is in progress
      launch(17'h0110, 17'h0200, 0);
      begin
         int i;
         for (i = 0; i < 500; i++) begin
            if (mb_ai == 17'h0104) break;
            @(posedge clk); #1;
         end
         chk("reach_cmp", mb_ai, 17'h0104);
      end
      exp_valid = 0;
      track = 0;
      #2 rst_n = 0;
      #1;
      chk("abort_bsy", bsy, 0);
      chk("abort_done", done, 0);
      chk("abort_hit", hit, 0);
      chk("abort_mb_ai", mb_ai, 0);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("abort_no_done", done_cnt, 0);
      search(17'h0110, 17'h0200, 0);
      chk("after_rst_hit", hit, 1);
      chk("after_rst_wa", wa, 17'h0100);

      // start while busy must be ignored
      launch(17'h0110, 17'h0200, 0);
      repeat (4) @(posedge clk);
      #1;
      chk("busy_bsy", bsy, 1);
      tib = 17'h0300; ctx = 17'h0100;
      start = 1;
      @(posedge clk); #1;
      start = 0;
      finish_search();
      repeat (5) @(posedge clk);
      #1;
      chk("busy_one_done", done_cnt, 1);
      chk("busy_hold_hit", hit, 1);
      chk("busy_hold_wa", wa, 17'h0100);
      chk("busy_hold_tn", tib_nxt, 17'h0206);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running required finished");
      $fatal(1, "timeout");
   end

endmodule
